// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the pipeline hazard controller
//
// Purpose: next-PC source encodings, bus-error trap cause and the hazard
// sequencer state enum shared by pipe_hazard_ctrl and its testbench.
// Ports: none (package).
package pipe_pkg;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;  // PC+4
  localparam logic [1:0] PCSEL_BR   = 2'b01;  // branch/jump target
  localparam logic [1:0] PCSEL_TVEC = 2'b10;  // mtvec
  localparam logic [1:0] PCSEL_EPC  = 2'b11;  // mepc

  localparam logic [1:0] CAUSE_BUSERR = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TRAP     = 2'd2
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
//
// Purpose: flags when the load in EX writes a register that the instruction
// in ID actually reads, so the front of the pipe must hold for one cycle.
// Ports:
//   i_rs1_id, i_rs2_id       in  5  source registers of the instruction in ID
//   i_rs1_used, i_rs2_used   in  1  ID instruction really reads that source
//   i_rd_ex                  in  5  destination of the instruction in EX
//   i_mem_r_ex               in  1  instruction in EX is a load
//   o_load_use               out 1  hazard detected
module load_use_detect (
  input  logic [4:0] i_rs1_id,
  input  logic [4:0] i_rs2_id,
  input  logic       i_rs1_used,
  input  logic       i_rs2_used,
  input  logic [4:0] i_rd_ex,
  input  logic       i_mem_r_ex,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_rs1_used && (i_rs1_id == i_rd_ex);
  assign w_rs2_hit = i_rs2_used && (i_rs2_id == i_rd_ex);

  // x0 is never really written, so a load to x0 cannot create a hazard.
  assign o_load_use = i_mem_r_ex && (i_rd_ex != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipe
//
// Purpose: drives PC and pipeline-latch enables/flushes and the next-PC
// select; resolves load-use stalls, taken branches, trap/mret entry and
// data-memory wait states (with a watchdog that turns a hung access into a
// bus-error trap).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   rs1_ID, rs2_ID, rs1_used_ID,
//   rs2_used_ID, rd_EX, mem_r_EX        load-use inputs
//   branch_taken_EX                     taken branch/jump resolved in EX
//   exp_vector_EX, mret_EX              exception code / mret in EX
//   mem_req_MEM, mem_ack                data-memory handshake
//   PC_EN .. MEM_WB_EN                  latch enables
//   IF_ID_flush .. EX_MEM_flush         bubble insertion
//   pc_sel                              next-PC source
//   trap_take, trap_cause, mret_take    CSR-unit pulses
//   stalled                             high while waiting on data memory
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int                WDOG_W   = 8,
  parameter logic [WDOG_W-1:0] WDOG_MAX = 8'd200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       rs1_used_ID,
  input  logic       rs2_used_ID,
  input  logic [4:0] rd_EX,
  input  logic       mem_r_EX,
  input  logic       branch_taken_EX,
  input  logic [1:0] exp_vector_EX,
  input  logic       mret_EX,
  input  logic       mem_req_MEM,
  input  logic       mem_ack,
  output logic       PC_EN,
  output logic       IF_ID_EN,
  output logic       ID_EX_EN,
  output logic       EX_MEM_EN,
  output logic       MEM_WB_EN,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       EX_MEM_flush,
  output logic [1:0] pc_sel,
  output logic       trap_take,
  output logic [1:0] trap_cause,
  output logic       mret_take,
  output logic       stalled
);

  localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WDOG_W-1:0] r_wdog;
  logic [1:0]        r_cause;
  logic              w_load_use;
  logic              w_wdog_done;

  load_use_detect u_load_use_detect (
    .i_rs1_id   (rs1_ID),
    .i_rs2_id   (rs2_ID),
    .i_rs1_used (rs1_used_ID),
    .i_rs2_used (rs2_used_ID),
    .i_rd_ex    (rd_EX),
    .i_mem_r_ex (mem_r_EX),
    .o_load_use (w_load_use)
  );

  assign w_wdog_done = (r_wdog == WDOG_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_wdog  <= '0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN && w_state_nxt == ST_MEM_WAIT) begin
        r_wdog  <= '0;
        // Pre-load the bus-error cause so the timeout cycle drives it from a flop.
        r_cause <= CAUSE_BUSERR;
      end else if (r_state == ST_RUN && w_state_nxt == ST_TRAP) begin
        r_cause <= exp_vector_EX;
      end else if (r_state == ST_MEM_WAIT && !w_wdog_done) begin
        r_wdog  <= r_wdog + WDOG_ONE;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    PC_EN        = 1'b1;
    IF_ID_EN     = 1'b1;
    ID_EX_EN     = 1'b1;
    EX_MEM_EN    = 1'b1;
    MEM_WB_EN    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    pc_sel       = PCSEL_SEQ;
    trap_take    = 1'b0;
    trap_cause   = 2'b00;
    mret_take    = 1'b0;
    stalled      = 1'b0;

    // Outputs sit at their defaults while reset is asserted, whatever the inputs.
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (mem_req_MEM && !mem_ack) begin
            // Freeze everything; hazards are re-evaluated once the pipe resumes.
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_EN    = 1'b0;
            EX_MEM_EN   = 1'b0;
            MEM_WB_EN   = 1'b0;
            w_state_nxt = ST_MEM_WAIT;
          end else if (exp_vector_EX != 2'b00) begin
            trap_take    = 1'b1;
            trap_cause   = exp_vector_EX;
            pc_sel       = PCSEL_TVEC;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            w_state_nxt  = ST_TRAP;
          end else if (mret_EX) begin
            mret_take    = 1'b1;
            pc_sel       = PCSEL_EPC;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            w_state_nxt  = ST_TRAP;
          end else if (branch_taken_EX) begin
            pc_sel      = PCSEL_BR;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (w_load_use) begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_flush = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          stalled = 1'b1;
          if (mem_ack) begin
            // Access retires this cycle; ack beats a coincident timeout.
            w_state_nxt = ST_RUN;
          end else if (w_wdog_done) begin
            // Redirect to mtvec, but keep the hung access out of write-back.
            trap_take    = 1'b1;
            trap_cause   = r_cause;
            pc_sel       = PCSEL_TVEC;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_EN    = 1'b0;
            w_state_nxt  = ST_TRAP;
          end else begin
            PC_EN     = 1'b0;
            IF_ID_EN  = 1'b0;
            ID_EX_EN  = 1'b0;
            EX_MEM_EN = 1'b0;
            MEM_WB_EN = 1'b0;
          end
        end

        ST_TRAP: begin
          // Discard the instruction fetched before the redirect took effect.
          IF_ID_flush = 1'b1;
          w_state_nxt = ST_RUN;
        end

        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic       rs1_used_ID, rs2_used_ID, mem_r_EX, branch_taken_EX, mret_EX;
  logic [1:0] exp_vector_EX;
  logic       mem_req_MEM, mem_ack;
  logic       PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN;
  logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic [1:0] pc_sel, trap_cause;
  logic       trap_take, mret_take, stalled;

  int n_vec = 0;
  int n_err = 0;
  logic [14:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WDOG_W(8), .WDOG_MAX(8'd200)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .mem_r_EX(mem_r_EX),
    .branch_taken_EX(branch_taken_EX), .exp_vector_EX(exp_vector_EX),
    .mret_EX(mret_EX), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_EX_EN(ID_EX_EN),
    .EX_MEM_EN(EX_MEM_EN), .MEM_WB_EN(MEM_WB_EN),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .pc_sel(pc_sel), .trap_take(trap_take), .trap_cause(trap_cause),
    .mret_take(mret_take), .stalled(stalled)
  );

  // {enables[4:0] PC..MEM_WB, flushes[2:0] IF_ID..EX_MEM, pc_sel, trap_take, trap_cause, mret_take, stalled}
  function automatic logic [14:0] mk(input logic [4:0] en, input logic [2:0] fl,
                                     input logic [1:0] pcs, input logic tt,
                                     input logic [1:0] tc, input logic mt, input logic st);
    return {en, fl, pcs, tt, tc, mt, st};
  endfunction

  localparam logic [14:0] E_DEF   = {5'b11111, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] E_LU    = {5'b00111, 3'b010, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] E_BR    = {5'b11111, 3'b110, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] E_MRET  = {5'b11111, 3'b111, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0};
  localparam logic [14:0] E_TSET  = {5'b11111, 3'b100, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] E_STR   = {5'b00000, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] E_STW   = {5'b00000, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [14:0] E_ACK   = {5'b11111, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [14:0] E_BUSE  = {5'b11110, 3'b111, 2'b10, 1'b1, 2'b11, 1'b0, 1'b1};

  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic [1:0] ex, input logic mt,
                        input logic rq, input logic ak);
    rs1_ID = r1; rs2_ID = r2; rs1_used_ID = u1; rs2_used_ID = u2;
    rd_EX = rd; mem_r_EX = mr; branch_taken_EX = br; exp_vector_EX = ex;
    mret_EX = mt; mem_req_MEM = rq; mem_ack = ak;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Push expectation with the stimulus, pop and compare mid-cycle, then move
  // to just after the next rising edge ready for the next drive.
  task automatic step(input string tag, input logic [14:0] e);
    logic [14:0] obs;
    logic [14:0] exp_v;
    sb_q.push_back(e);
    @(negedge clk);
    obs = {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
           IF_ID_flush, ID_EX_flush, EX_MEM_flush,
           pc_sel, trap_take, trap_cause, mret_take, stalled};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL %s scoreboard empty observed=%h expected=<entry>", tag, obs);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;

    // Reset: defaults even with a load-use pattern on the inputs.
    set_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step("reset_hold", E_DEF);
    rst_n = 1'b1;
    idle();
    step("after_reset", E_DEF);

    // 1: lw x5 / add x6,x5,x1 -> one bubble, then free-running.
    set_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", E_LU);
    idle();
    step("lu_after", E_DEF);
    set_in(5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", E_LU);

    // 2: no stall for rd=x0, unused matching source, or non-load.
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step("lu_rd0", E_DEF);
    set_in(5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step("lu_rs1_unused", E_DEF);
    set_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step("lu_not_load", E_DEF);

    // 3: branch beats load-use.
    set_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step("br_over_lu", E_BR);
    idle();
    step("br_after", E_DEF);

    // 4: exception trap, settle cycle, back to RUN.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    step("trap_exc", mk(5'b11111, 3'b111, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0));
    idle();
    step("trap_settle", E_TSET);
    step("trap_run", E_DEF);

    // Trap beats mret and branch; then a plain mret.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    step("trap_prio", mk(5'b11111, 3'b111, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0));
    idle();
    step("trap_prio_settle", E_TSET);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    step("mret", E_MRET);
    idle();
    step("mret_settle", E_TSET);
    step("mret_run", E_DEF);

    // Request with ack in the same cycle: no stall.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    step("req_ack_nostall", E_DEF);

    // 5: five cycles without ack with a branch pending, then ack, then branch.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    step("wait_enter", E_STR);
    for (int i = 0; i < 4; i++) step("wait_hold", E_STW);
    mem_ack = 1'b1;
    step("wait_ack", E_ACK);
    mem_req_MEM = 1'b0;
    mem_ack = 1'b0;
    step("wait_branch", E_BR);
    idle();
    step("wait_done", E_DEF);

    // 6: hung access -> bus-error trap after 200 wait cycles.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step("wdog_enter", E_STR);
    for (int i = 0; i < 200; i++) step("wdog_hold", E_STW);
    step("wdog_buserr", E_BUSE);
    idle();
    step("wdog_settle", E_TSET);
    step("wdog_run", E_DEF);

    // Ack coinciding with the timeout wins.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step("wdog2_enter", E_STR);
    for (int i = 0; i < 200; i++) step("wdog2_hold", E_STW);
    mem_ack = 1'b1;
    step("wdog2_ack_wins", E_ACK);
    idle();
    step("wdog2_run", E_DEF);

    // Reset during a wait: no pulse, back in RUN.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step("rstw_enter", E_STR);
    for (int i = 0; i < 3; i++) step("rstw_hold", E_STW);
    rst_n = 1'b0;
    step("rstw_in_reset", E_DEF);
    rst_n = 1'b1;
    idle();
    step("rstw_run", E_DEF);

    // Reset during the trap settle cycle.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step("rstt_trap", mk(5'b11111, 3'b111, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0));
    idle();
    rst_n = 1'b0;
    step("rstt_in_reset", E_DEF);
    rst_n = 1'b1;
    step("rstt_run", E_DEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
